competition_ctrl: RTL
=====================

COMPETITION_CTRL -- requirements
Module: competition_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000000, SHALL be the clk cycles per one-second tick.
REQ-002 Parameter ANSWER_SEC, default 9, SHALL be the answer-window length in seconds, range 1..15.
REQ-003 Parameter BUZZ_CYC, default 25000000, SHALL be the buzz_req pulse length in clk cycles.
REQ-004 clk  input  1  SHALL be the single system clock; all state is rising-edge clocked.
REQ-005 rst  input  1  SHALL be the reset: asynchronous and active-high.
REQ-006 start  input  1  SHALL be the raw host "start round" button, asynchronous to clk.
REQ-007 player_btn  input  4  SHALL be the raw player buttons, bit i = player i, asynchronous to clk.
REQ-008 view  output  3  SHALL be the screen selector for the downstream display stage: 1 IDLE, 2 ARMED, 3 LOCKED, 4 TIMEOUT.
REQ-009 play_count  output  4  SHALL be the completed-round count, BCD digit 0..9.
REQ-010 winner  output  3  SHALL be the locked player index 0..3, or 7 when no player holds the lock.
REQ-011 countdown  output  4  SHALL be the remaining answer-window seconds.
REQ-012 buzz_req  output  1  SHALL be the buzzer enable pulse.

Function
REQ-013 start and each player_btn bit SHALL pass a 2-flop synchronizer, then a rising-edge detector.
REQ-014 Each detected press SHALL be a 1-cycle event, 3 cycles after the raw edge settles; levels held high SHALL NOT re-trigger.
REQ-015 FSM states SHALL be IDLE, ARMED, LOCKED and TIMEOUT; view SHALL be registered from the state.
REQ-016 IDLE: a start event SHALL go to ARMED.
  - countdown <= ANSWER_SEC; tick divider cleared.
  - Player events in IDLE SHALL be ignored.
REQ-017 ARMED: the tick divider SHALL count 0..TICK_DIV-1; countdown SHALL decrement by 1 when it wraps.
REQ-018 ARMED: any player event SHALL go to LOCKED.
  - winner <= lowest-index player with an event that cycle (simultaneous presses: lowest index wins).
  - buzz_req asserted.
REQ-019 ARMED: countdown reaching 0 with no player event that cycle SHALL go to TIMEOUT with buzz_req asserted.
  - Player event on the same cycle as expiry: the player event SHALL win (LOCKED).
REQ-020 LOCKED and TIMEOUT SHALL ignore player events; a start event SHALL return to IDLE.
REQ-021 play_count SHALL increment by 1 on each entry to LOCKED or TIMEOUT, wrapping 9->0; no other event SHALL change it.
REQ-022 A start event in ARMED SHALL be ignored.
REQ-023 Once asserted, buzz_req SHALL stay high for exactly BUZZ_CYC cycles.
  - Runs regardless of later state changes.
  - A new trigger while active SHALL restart the full length.
REQ-024 winner SHALL return to 7 on entry to IDLE and SHALL hold its value through LOCKED.
REQ-025 countdown SHALL hold its value in LOCKED and TIMEOUT (0 in TIMEOUT); it SHALL be don't-care-free, i.e. always a defined value.

Reset
REQ-026 While rst=1, asynchronously: state IDLE, view=1, play_count=0, winner=7, countdown=0, buzz_req=0, divider, synchronizers and edge registers 0.
REQ-027 Reset asserted mid-round SHALL abandon the round without incrementing play_count; a button held through reset release SHALL NOT generate an event.

Verification
REQ-028 Bench (TICK_DIV=4, ANSWER_SEC=3, BUZZ_CYC=5) SHALL cover:
  - Reset, pulse start -> view 1->2, countdown=3; no press -> countdown 3,2,1,0 every 4 cycles, view=4, play_count=1, buzz_req high 5 cycles.
  - Arm, press player_btn=4'b0110 in one cycle -> winner=1, view=3, play_count increments, later presses leave winner=1.
  - Press player 2 in IDLE -> no state change, winner=7, play_count unchanged.
  - Ten completed rounds -> play_count 1..9 then 0.
  - Player press on the expiry cycle -> LOCKED, not TIMEOUT.
  - Assert rst in ARMED with player_btn held -> all outputs at reset values, no event after release, play_count unchanged.

Source files
------------

// File: rtl/competition_ctrl_if.sv
// Quiz-round controller bus: host/player buttons in, display/buzzer controls out.
//   master : drives start/player_btn, observes the display and buzzer fields
//   slave  : the controller side
interface competition_ctrl_if;
  logic       start;
  logic [3:0] player_btn;
  logic [2:0] view;
  logic [3:0] play_count;
  logic [2:0] winner;
  logic [3:0] countdown;
  logic       buzz_req;

  modport master (output start, player_btn,
                  input  view, play_count, winner, countdown, buzz_req);
  modport slave  (input  start, player_btn,
                  output view, play_count, winner, countdown, buzz_req);
endinterface

// File: rtl/competition_ctrl.sv
// competition_ctrl: quiz-round controller.
//   clk, rst      : system clock, async active-high reset
//   bus.start     : raw host button (async) - arms a round / returns to idle
//   bus.player_btn: raw player buttons (async), bit i = player i
//   bus.view      : 1 IDLE, 2 ARMED, 3 LOCKED, 4 TIMEOUT
//   bus.play_count: completed rounds, BCD 0..9
//   bus.winner    : locked player, 7 when none
//   bus.countdown : remaining answer seconds
//   bus.buzz_req  : buzzer pulse, BUZZ_CYC cycles long

// One button lane: 2-flop synchronizer plus rising-edge history flop.
module competition_ctrl_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic en,
  output logic rise
);
  logic [2:0] sr;
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else     sr <= {sr[1:0], d};
  assign rise = en & sr[1] & ~sr[2];
endmodule

module competition_ctrl #(
  parameter int TICK_DIV   = 100000000,
  parameter int ANSWER_SEC = 9,
  parameter int BUZZ_CYC   = 25000000
) (
  input logic               clk,
  input logic               rst,
  competition_ctrl_if.slave bus
);
  localparam int NUM_LANES = 5;  // lanes 0..3 players, lane 4 start
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = $clog2(BUZZ_CYC + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_LOCKED, S_TIMEOUT} state_t;

  state_t                 state_q, state_d;
  logic [NUM_LANES-1:0]   raw, ev;
  logic [2:0]             vld_pipe;
  logic [DW-1:0]          div_q, div_d;
  logic [3:0]             cnt_q, cnt_d, pc_q;
  logic [2:0]             win_q, win_d, view_q, view_d;
  logic [BW-1:0]          buzz_q;
  logic                   buzz_set, round_done;

  assign raw = {bus.start, bus.player_btn};

  // Edge events are held off until the synchronizers have refilled after
  // reset, so a button held through reset release never looks like a press.
  always_ff @(posedge clk or posedge rst)
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[1:0], 1'b1};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    competition_ctrl_sync u_sync (
      .clk(clk), .rst(rst), .d(raw[i]), .en(vld_pipe[2]), .rise(ev[i])
    );
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    win_d      = win_q;
    buzz_set   = 1'b0;
    round_done = 1'b0;
    case (state_q)
      S_IDLE: if (ev[4]) begin
        state_d = S_ARMED;
        cnt_d   = 4'(ANSWER_SEC);
        div_d   = '0;
      end
      S_ARMED: begin
        if (div_q == DIV_MAX) begin
          div_d = '0;
          cnt_d = cnt_q - 4'd1;
        end else begin
          div_d = div_q + DW'(1);
        end
        // A press on the expiry cycle beats the timeout; countdown freezes.
        if (|ev[3:0]) begin
          state_d    = S_LOCKED;
          cnt_d      = cnt_q;
          buzz_set   = 1'b1;
          round_done = 1'b1;
          for (int i = 3; i >= 0; i--)
            if (ev[i]) win_d = 3'(i);
        end else if (div_q == DIV_MAX && cnt_q <= 4'd1) begin
          state_d    = S_TIMEOUT;
          cnt_d      = 4'd0;
          buzz_set   = 1'b1;
          round_done = 1'b1;
        end
      end
      S_LOCKED, S_TIMEOUT: if (ev[4]) begin
        state_d = S_IDLE;
        win_d   = 3'd7;
      end
      default: state_d = S_IDLE;
    endcase
    case (state_d)
      S_ARMED:   view_d = 3'd2;
      S_LOCKED:  view_d = 3'd3;
      S_TIMEOUT: view_d = 3'd4;
      default:   view_d = 3'd1;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div_q  <= '0;
      cnt_q  <= '0;
      win_q  <= 3'd7;
      view_q <= 3'd1;
      pc_q   <= '0;
      buzz_q <= '0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      win_q  <= win_d;
      view_q <= view_d;
      if (round_done) pc_q <= (pc_q == 4'd9) ? 4'd0 : pc_q + 4'd1;
      // Retrigger reloads the full length even mid-pulse.
      if (buzz_set)          buzz_q <= BW'(BUZZ_CYC);
      else if (buzz_q != '0) buzz_q <= buzz_q - BW'(1);
    end

  assign bus.view       = view_q;
  assign bus.play_count = pc_q;
  assign bus.winner     = win_q;
  assign bus.countdown  = cnt_q;
  assign bus.buzz_req   = (buzz_q != '0);
endmodule
